// File: rtl/ppu_types_pkg.sv
// Shared PPU screen geometry and colour constants.
package ppu_types_pkg;
  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 144;
  localparam int COLOR_W_DEF  = 2;
  localparam logic [7:0] COLOR_TRANSPARENT_IDX = 8'd0;
endpackage

// File: rtl/ppu_util_pkg.sv
// Pixel mixing helpers shared by PPU stages.
package ppu_util_pkg;
  import ppu_types_pkg::*;

  // OBJ hides behind BG only when flagged and BG is opaque.
  function automatic logic obj_wins(
    input logic [7:0] bg,
    input logic [7:0] obj,
    input logic       prio,
    input logic       valid
  );
    return valid && (obj != COLOR_TRANSPARENT_IDX) &&
           !(prio && (bg != COLOR_TRANSPARENT_IDX));
  endfunction
endpackage

// File: rtl/fb_bank_ram.sv
// Banked framebuffer RAM: one write port, one registered read port.
module fb_bank_ram #(
  parameter int WORDS   = 23040,
  parameter int NB      = 2,
  parameter int COLOR_W = 2,
  parameter int AW      = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic               wbank,
  input  logic [AW-1:0]      waddr,
  input  logic [COLOR_W-1:0] wdata,
  input  logic               re,
  input  logic               rbank,
  input  logic [AW-1:0]      raddr,
  output logic [COLOR_W-1:0] rdata
);
  localparam int RAW = $clog2(NB * WORDS);

  logic [COLOR_W-1:0] mem [NB*WORDS];
  logic [COLOR_W-1:0] rdata_q;
  logic [RAW-1:0]     wa;
  logic [RAW-1:0]     ra;
  logic               unused_bank;

  function automatic logic [RAW-1:0] base(input logic b);
    return (NB > 1 && b) ? RAW'(WORDS) : '0;
  endfunction

  assign unused_bank = wbank ^ rbank;
  assign wa = base(wbank) + RAW'(waddr);
  assign ra = base(rbank) + RAW'(raddr);

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wdata;
  end

  // Read-before-write: same-address collisions return old data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata_q <= '0;
    else if (re) rdata_q <= mem[ra];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/frame_compositor.sv
// Mode-3 BG/OBJ pixel mixer writing a double-buffered framebuffer.
module frame_compositor
  import ppu_types_pkg::*;
  import ppu_util_pkg::*;
#(
  parameter int SCREEN_W      = SCREEN_W_DEF,
  parameter int SCREEN_H      = SCREEN_H_DEF,
  parameter int COLOR_W       = COLOR_W_DEF,
  parameter int DOUBLE_BUFFER = 1,
  parameter int ADDR_W        = $clog2(SCREEN_W * SCREEN_H)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pixel_transfer_en,
  input  logic               stall,
  input  logic               flush,
  input  logic               frame_reset,
  input  logic [7:0]         scx,
  input  logic               bg_valid,
  input  logic [COLOR_W-1:0] bg_color,
  output logic               bg_ready,
  input  logic               obj_valid,
  input  logic [COLOR_W-1:0] obj_color,
  input  logic               obj_bg_prio,
  output logic               obj_ready,
  output logic [7:0]         pixel_x,
  output logic               line_done,
  output logic               frame_done,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [COLOR_W-1:0] rd_data,
  output logic               front_bank
);
  localparam int NPIX = SCREEN_W * SCREEN_H;
  localparam int NB   = 1 + DOUBLE_BUFFER;

  logic [7:0] x_q, x_d, y_q, y_d;
  logic [2:0] disc_q, disc_d;
  logic       front_q, front_d;
  logic       ld_q, ld_d, fd_q, fd_d;
  logic       oob_q;
  logic       consume, drop, wr_en, eol, eof, in_range;
  logic [ADDR_W-1:0]  wr_addr;
  logic [COLOR_W-1:0] wr_data, ram_rdata;
  logic       unused_scx;

  assign unused_scx = ^scx[7:3];

  assign consume = pixel_transfer_en & bg_valid & ~stall &
                   ~flush & ~frame_reset;
  assign bg_ready  = consume;
  assign obj_ready = consume & obj_valid;
  assign drop  = consume & (disc_q != 3'd0);
  assign wr_en = consume & (disc_q == 3'd0);
  assign eol = (x_q == 8'(SCREEN_W - 1));
  assign eof = (y_q == 8'(SCREEN_H - 1));

  assign wr_data = obj_wins(8'(bg_color), 8'(obj_color), obj_bg_prio,
                            obj_valid) ? obj_color : bg_color;
  assign wr_addr = ADDR_W'(y_q) * ADDR_W'(SCREEN_W) + ADDR_W'(x_q);

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    disc_d  = disc_q;
    front_d = front_q;
    ld_d    = 1'b0;
    fd_d    = 1'b0;
    if (frame_reset) begin
      x_d    = '0;
      y_d    = '0;
      disc_d = '0;
    end else if (flush) begin
      x_d    = '0;
      disc_d = scx[2:0];
    end else if (drop) begin
      disc_d = disc_q - 3'd1;
    end else if (wr_en) begin
      if (eol) begin
        x_d  = '0;
        ld_d = 1'b1;
        if (eof) begin
          y_d  = '0;
          fd_d = 1'b1;
          if (DOUBLE_BUFFER != 0) front_d = ~front_q;
        end else begin
          y_d = y_q + 8'd1;
        end
      end else begin
        x_d = x_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      disc_q  <= '0;
      front_q <= 1'b0;
      ld_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      disc_q  <= disc_d;
      front_q <= front_d;
      ld_q    <= ld_d;
      fd_q    <= fd_d;
    end
  end

  assign in_range = (32'(rd_addr) < 32'(NPIX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      oob_q <= 1'b0;
    else if (rd_en) oob_q <= ~in_range;
  end

  fb_bank_ram #(
    .WORDS   (NPIX),
    .NB      (NB),
    .COLOR_W (COLOR_W),
    .AW      (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en),
    .wbank (~front_q),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (rd_en & in_range),
    .rbank (front_q),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  assign rd_data    = oob_q ? '0 : ram_rdata;
  assign pixel_x    = x_q;
  assign line_done  = ld_q;
  assign frame_done = fd_q;
  assign front_bank = front_q;
endmodule

// File: tb/tb_frame_compositor.sv
// Directed bench for frame_compositor: discard, mix, stall, swap, aborts.
module tb_frame_compositor;
  localparam int W    = 160;
  localparam int H    = 144;
  localparam int NPIX = W * H;
  localparam int AW   = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          pte, stall, flush, frame_reset;
  logic [7:0]    scx;
  logic          bg_valid;
  logic [1:0]    bg_color;
  logic          bg_ready;
  logic          obj_valid;
  logic [1:0]    obj_color;
  logic          obj_bg_prio;
  logic          obj_ready;
  logic [7:0]    pixel_x;
  logic          line_done, frame_done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [1:0]    rd_data;
  logic          front_bank;

  frame_compositor dut (
    .clk               (clk),
    .reset             (reset),
    .pixel_transfer_en (pte),
    .stall             (stall),
    .flush             (flush),
    .frame_reset       (frame_reset),
    .scx               (scx),
    .bg_valid          (bg_valid),
    .bg_color          (bg_color),
    .bg_ready          (bg_ready),
    .obj_valid         (obj_valid),
    .obj_color         (obj_color),
    .obj_bg_prio       (obj_bg_prio),
    .obj_ready         (obj_ready),
    .pixel_x           (pixel_x),
    .line_done         (line_done),
    .frame_done        (frame_done),
    .rd_en             (rd_en),
    .rd_addr           (rd_addr),
    .rd_data           (rd_data),
    .front_bank        (front_bank)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] bg;
    logic       ov;
    logic [1:0] oc;
    logic       op;
    logic [1:0] exp;
  } vec_t;

  vec_t tbl [5];
  int nchk = 0;
  int nerr = 0;
  int ld_cnt = 0;
  int fd_cnt = 0;
  int bx = 0;
  int by = 0;
  logic [1:0] d;

  always @(negedge clk) begin
    if (line_done)  ld_cnt++;
    if (frame_done) fd_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic advance();
    if (bx == W - 1) begin
      bx = 0;
      by = (by == H - 1) ? 0 : by + 1;
    end else begin
      bx++;
    end
  endtask

  task automatic run_pixels(input int n);
    bg_valid  = 1'b1;
    obj_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      bg_color = 2'((bx + by) % 4);
      tick();
      advance();
    end
    bg_valid = 1'b0;
  endtask

  task automatic do_read(input int a, output logic [1:0] q);
    rd_en   = 1'b1;
    rd_addr = AW'(a);
    tick();
    q     = rd_data;
    rd_en = 1'b0;
  endtask

  initial begin
    tbl[0] = '{bg: 2'd2, ov: 1'b1, oc: 2'd3, op: 1'b0, exp: 2'd3};
    tbl[1] = '{bg: 2'd2, ov: 1'b1, oc: 2'd3, op: 1'b1, exp: 2'd2};
    tbl[2] = '{bg: 2'd0, ov: 1'b1, oc: 2'd1, op: 1'b1, exp: 2'd1};
    tbl[3] = '{bg: 2'd1, ov: 1'b1, oc: 2'd0, op: 1'b0, exp: 2'd1};
    tbl[4] = '{bg: 2'd3, ov: 1'b0, oc: 2'd2, op: 1'b0, exp: 2'd3};

    reset = 1'b1; pte = 1'b1; stall = 1'b0; flush = 1'b0;
    frame_reset = 1'b0; scx = 8'h00; bg_valid = 1'b0;
    bg_color = 2'd0; obj_valid = 1'b0; obj_color = 2'd0;
    obj_bg_prio = 1'b0; rd_en = 1'b0; rd_addr = '0;
    tick();
    chk("rst_pixel_x", pixel_x, 0);
    chk("rst_line_done", line_done, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_front_bank", front_bank, 0);
    reset = 1'b0;
    tick();

    // flush with a pixel waiting: blocked, then dropped under scx=3
    scx = 8'hFB; flush = 1'b1; bg_valid = 1'b1; bg_color = 2'd0;
    #1 chk("flush_blocks_ready", bg_ready, 0);
    tick();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("discard_pop", bg_ready, 1);
      tick();
    end
    chk("discard_x_hold", pixel_x, 0);
    bg_color = 2'd1; tick();
    bg_color = 2'd2; tick();
    chk("discard_x_after", pixel_x, 2);
    bx = 2;

    foreach (tbl[i]) begin
      bg_color = tbl[i].bg; obj_valid = tbl[i].ov;
      obj_color = tbl[i].oc; obj_bg_prio = tbl[i].op;
      #1 chk($sformatf("mix_obj_ready_%0d", i), obj_ready, tbl[i].ov);
      tick();
      bx++;
    end
    obj_valid = 1'b0; obj_bg_prio = 1'b0;
    chk("mix_x", pixel_x, 7);

    bg_color = 2'd3; stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("stall_no_pop", bg_ready, 0);
      tick();
    end
    stall = 1'b0; bg_valid = 1'b0;
    repeat (5) tick();
    chk("gap_x_frozen", pixel_x, 7);
    run_pixels(1);
    chk("resume_x", pixel_x, 8);

    run_pixels(NPIX - 8);
    chk("frameA_done_pulse", frame_done, 1);
    tick();
    chk("frameA_done_1cyc", frame_done, 0);
    chk("frameA_lines", ld_cnt, 144);
    chk("frameA_frames", fd_cnt, 1);
    chk("frameA_swap", front_bank, 1);
    chk("frameA_x_wrap", pixel_x, 0);

    do_read(0, d); chk("rd_addr0", d, 1);
    do_read(1, d); chk("rd_addr1", d, 2);
    foreach (tbl[i]) begin
      do_read(2 + i, d);
      chk($sformatf("mix_store_%0d", i), d, tbl[i].exp);
    end
    do_read(7, d); chk("rd_after_gap", d, 3);
    do_read(161, d); chk("rd_addr161", d, 2);
    rd_addr = '0; tick();
    chk("rd_hold", rd_data, 2);
    do_read(NPIX - 1, d); chk("rd_last", d, 2);
    do_read(NPIX, d); chk("rd_oob", d, 0);

    // next frame writes land in the back bank only
    bx = 0; by = 0;
    bg_valid = 1'b1; bg_color = 2'd3; tick(); advance();
    bg_valid = 1'b0;
    do_read(0, d); chk("back_isolated", d, 1);
    run_pixels(70 * W + 40 - 1);
    chk("pre_abort_x", pixel_x, 40);
    frame_reset = 1'b1; bg_valid = 1'b1;
    #1 chk("abort_blocks_ready", bg_ready, 0);
    tick();
    frame_reset = 1'b0; bg_valid = 1'b0;
    tick();
    chk("abort_x", pixel_x, 0);
    chk("abort_no_swap", front_bank, 1);
    chk("abort_no_frame_done", fd_cnt, 1);
    chk("abort_lines", ld_cnt, 144 + 70);

    bx = 0; by = 0;
    bg_valid = 1'b1; bg_color = 2'd2; tick(); advance();
    run_pixels(NPIX - 2);
    bg_valid = 1'b1; bg_color = 2'((bx + by) % 4);
    rd_en = 1'b1; rd_addr = '0;
    tick(); advance();
    bg_valid = 1'b0; rd_en = 1'b0;
    chk("swap_edge_read_old", rd_data, 1);
    chk("frameB_done_pulse", frame_done, 1);
    chk("frameB_swap", front_bank, 0);
    tick();
    chk("frameB_lines", ld_cnt, 2 * 144 + 70);
    chk("frameB_frames", fd_cnt, 2);
    do_read(0, d); chk("abort_next_at_addr0", d, 2);
    do_read(1, d); chk("frameB_addr1", d, 1);

    run_pixels(3);
    chk("pre_reset_x", pixel_x, 3);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_x", pixel_x, 0);
    chk("async_rst_rd_data", rd_data, 0);
    chk("async_rst_front", front_bank, 0);
    chk("async_rst_line_done", line_done, 0);
    reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
